// File: rtl/flag_branch_ctrl.sv
// Flag register, conditional branch/call/return resolver and return-address stack
// for the PIM controller; redirects the sequencer PC via pc_load/pc_next.
module flag_branch_ctrl #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_we,
    input  logic            Col,
    input  logic            Ziw1,
    input  logic            Ziw2,
    input  logic            Zimm,
    input  logic            Co,
    input  logic            Call,
    input  logic            Sign,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [3:0]      br_cond,
    input  logic            br_is_call,
    input  logic            br_is_ret,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] pc_cur,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_next,
    output logic            br_done,
    output logic [6:0]      flags_q,
    output logic            stk_ovf,
    output logic            stk_unf,
    input  logic            err_clr
);

    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      cond_r;
    logic            call_r;
    logic            ret_r;
    logic [PC_W-1:0] target_r;
    logic [PC_W-1:0] pc_r;
    logic            taken_r;
    logic [SPW-1:0]  sp;
    logic [PC_W-1:0] stack_mem [STACK_DEPTH];

    logic            flag_col;
    logic            flag_ziw1;
    logic            flag_ziw2;
    logic            flag_zimm;
    logic            flag_co;
    logic            flag_call;
    logic            flag_sign;
    logic            cond_true;

    assign flag_col  = flags_q[0];
    assign flag_ziw1 = flags_q[1];
    assign flag_ziw2 = flags_q[2];
    assign flag_zimm = flags_q[3];
    assign flag_co   = flags_q[4];
    assign flag_call = flags_q[5];
    assign flag_sign = flags_q[6];

    always_comb begin
        cond_true = 1'b0;
        case (cond_r)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = flag_col;
            4'd2:    cond_true = ~flag_col;
            4'd3:    cond_true = flag_ziw1;
            4'd4:    cond_true = ~flag_ziw1;
            4'd5:    cond_true = flag_ziw2;
            4'd6:    cond_true = ~flag_ziw2;
            4'd7:    cond_true = flag_zimm;
            4'd8:    cond_true = ~flag_zimm;
            4'd9:    cond_true = flag_co;
            4'd10:   cond_true = ~flag_co;
            4'd11:   cond_true = flag_call;
            4'd12:   cond_true = flag_sign;
            4'd13:   cond_true = ~flag_sign;
            4'd14:   cond_true = flag_ziw1 & flag_ziw2;
            default: cond_true = 1'b0;
        endcase
    end

    logic            resp_taken;
    logic            is_ret;
    logic            is_call;
    logic            stk_empty;
    logic            stk_full;
    logic            do_push;
    logic            do_pop;
    logic            set_ovf;
    logic            set_unf;
    logic            do_jump;
    logic [SPW-1:0]  sp_minus1;
    logic [PC_W-1:0] jump_addr;

    // A request with both call and ret set behaves as a return.
    always_comb begin
        is_ret     = ret_r;
        is_call    = call_r & ~ret_r;
        stk_empty  = (sp == '0);
        stk_full   = (sp == SP_FULL);
        sp_minus1  = sp - SPW'(1);
        resp_taken = (state == RESP) && taken_r;
        do_pop     = resp_taken && is_ret && !stk_empty;
        do_push    = resp_taken && is_call && !stk_full;
        set_unf    = resp_taken && is_ret && stk_empty;
        set_ovf    = resp_taken && is_call && stk_full;
        do_jump    = resp_taken && !set_unf && !set_ovf;
        jump_addr  = is_ret ? stack_mem[sp_minus1[AW-1:0]] : target_r;
    end

    // Stack storage carries no reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[sp[AW-1:0]] <= pc_r + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            br_ready <= 1'b1;
            pc_load  <= 1'b0;
            pc_next  <= '0;
            br_done  <= 1'b0;
            flags_q  <= '0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
            sp       <= '0;
            cond_r   <= '0;
            call_r   <= 1'b0;
            ret_r    <= 1'b0;
            target_r <= '0;
            pc_r     <= '0;
            taken_r  <= 1'b0;
        end else begin
            br_done <= 1'b0;
            pc_load <= 1'b0;

            if (flag_we) begin
                flags_q <= {Sign, Call, Co, Zimm, Ziw2, Ziw1, Col};
            end

            // Clear first so an error raised in the same cycle survives.
            if (err_clr) begin
                stk_ovf <= 1'b0;
                stk_unf <= 1'b0;
            end
            if (set_ovf) begin
                stk_ovf <= 1'b1;
            end
            if (set_unf) begin
                stk_unf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (br_valid) begin
                        cond_r   <= br_cond;
                        call_r   <= br_is_call;
                        ret_r    <= br_is_ret;
                        target_r <= br_target;
                        pc_r     <= pc_cur;
                        br_ready <= 1'b0;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    taken_r <= cond_true;
                    state   <= RESP;
                end
                RESP: begin
                    br_done <= 1'b1;
                    if (do_jump) begin
                        pc_load <= 1'b1;
                        pc_next <= jump_addr;
                    end
                    if (do_push) begin
                        sp <= sp + SPW'(1);
                    end else if (do_pop) begin
                        sp <= sp_minus1;
                    end
                    br_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    br_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Bench for flag_branch_ctrl: directed scenarios followed by random requests,
// all compared against a queue-based reference model of flags, stack and error bits.
module tb_flag_branch_ctrl;

    localparam int PC_W  = 10;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flag_we;
    logic            Col, Ziw1, Ziw2, Zimm, Co, Call, Sign;
    logic            br_valid;
    logic            br_ready;
    logic [3:0]      br_cond;
    logic            br_is_call;
    logic            br_is_ret;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc_cur;
    logic            pc_load;
    logic [PC_W-1:0] pc_next;
    logic            br_done;
    logic [6:0]      flags_q;
    logic            stk_ovf;
    logic            stk_unf;
    logic            err_clr;

    always #5 clk = ~clk;

    flag_branch_ctrl #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flag_we   (flag_we),
        .Col       (Col),
        .Ziw1      (Ziw1),
        .Ziw2      (Ziw2),
        .Zimm      (Zimm),
        .Co        (Co),
        .Call      (Call),
        .Sign      (Sign),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_is_call(br_is_call),
        .br_is_ret (br_is_ret),
        .br_target (br_target),
        .pc_cur    (pc_cur),
        .pc_load   (pc_load),
        .pc_next   (pc_next),
        .br_done   (br_done),
        .flags_q   (flags_q),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf),
        .err_clr   (err_clr)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [6:0]      m_flags;
    logic [PC_W-1:0] m_stack[$];
    logic            m_ovf;
    logic            m_unf;

    // Flag vector layout {Sign,Call,Co,Zimm,Ziw2,Ziw1,Col}
    function automatic logic cond_holds(input logic [3:0] c, input logic [6:0] f);
        logic result;
        result = 1'b0;
        case (c)
            4'd0:  result = 1'b1;
            4'd1:  result = f[0];
            4'd2:  result = !f[0];
            4'd3:  result = f[1];
            4'd4:  result = !f[1];
            4'd5:  result = f[2];
            4'd6:  result = !f[2];
            4'd7:  result = f[3];
            4'd8:  result = !f[3];
            4'd9:  result = f[4];
            4'd10: result = !f[4];
            4'd11: result = f[5];
            4'd12: result = f[6];
            4'd13: result = !f[6];
            4'd14: result = f[1] && f[2];
            4'd15: result = 1'b0;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_flags(input logic [6:0] f);
        {Sign, Call, Co, Zimm, Ziw2, Ziw1, Col} = f;
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic flag_write(input logic [6:0] f);
        flag_we = 1'b1;
        drive_flags(f);
        tick();
        flag_we = 1'b0;
        m_flags = f;
        checkOutput("flags_write", 32'(flags_q), 32'(m_flags));
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        checkOutput("ovf_cleared", 32'(stk_ovf), 0);
        checkOutput("unf_cleared", 32'(stk_unf), 0);
    endtask

    // One full request: accept edge, EVAL edge, RESP edge; response checked after the third.
    task automatic applyStimulus(input logic [3:0] cond, input logic is_call, input logic is_ret,
                                 input logic [PC_W-1:0] target, input logic [PC_W-1:0] pc,
                                 input logic we_acc, input logic [6:0] f_acc,
                                 input logic we_ev, input logic [6:0] f_ev,
                                 input logic eclr);
        logic            taken;
        logic            exp_load;
        logic [PC_W-1:0] exp_pc;
        logic [PC_W-1:0] ret_pc;

        checkOutput("ready_idle", 32'(br_ready), 1);
        br_valid   = 1'b1;
        br_cond    = cond;
        br_is_call = is_call;
        br_is_ret  = is_ret;
        br_target  = target;
        pc_cur     = pc;
        flag_we    = we_acc;
        drive_flags(f_acc);
        tick();
        if (we_acc) m_flags = f_acc;

        br_valid   = 1'b0;
        br_cond    = 4'($urandom);
        br_is_call = 1'($urandom);
        br_is_ret  = 1'($urandom);
        br_target  = PC_W'($urandom);
        pc_cur     = PC_W'($urandom);
        flag_we    = we_ev;
        drive_flags(f_ev);
        checkOutput("ready_busy", 32'(br_ready), 0);
        checkOutput("done_early1", 32'(br_done), 0);
        checkOutput("load_early1", 32'(pc_load), 0);
        tick();
        taken = cond_holds(cond, m_flags);
        if (we_ev) m_flags = f_ev;

        flag_we = 1'b0;
        err_clr = eclr;
        checkOutput("done_early2", 32'(br_done), 0);
        checkOutput("load_early2", 32'(pc_load), 0);
        tick();
        err_clr = 1'b0;

        if (eclr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        exp_load = 1'b0;
        exp_pc   = '0;
        if (taken) begin
            if (is_ret) begin
                if (m_stack.size() == 0) m_unf = 1'b1;
                else begin
                    exp_load = 1'b1;
                    exp_pc   = m_stack.pop_back();
                end
            end else if (is_call) begin
                if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                else begin
                    ret_pc = pc + 1'b1;
                    m_stack.push_back(ret_pc);
                    exp_load = 1'b1;
                    exp_pc   = target;
                end
            end else begin
                exp_load = 1'b1;
                exp_pc   = target;
            end
        end

        checkOutput("br_done", 32'(br_done), 1);
        checkOutput("pc_load", 32'(pc_load), 32'(exp_load));
        if (exp_load) checkOutput("pc_next", 32'(pc_next), 32'(exp_pc));
        checkOutput("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
        checkOutput("stk_unf", 32'(stk_unf), 32'(m_unf));
        checkOutput("flags_q", 32'(flags_q), 32'(m_flags));
    endtask

    initial begin
        rst_n      = 1'b0;
        flag_we    = 1'b0;
        drive_flags(7'h00);
        br_valid   = 1'b0;
        br_cond    = '0;
        br_is_call = 1'b0;
        br_is_ret  = 1'b0;
        br_target  = '0;
        pc_cur     = '0;
        err_clr    = 1'b0;
        model_reset();

        tick();
        tick();
        checkOutput("rst_ready", 32'(br_ready), 1);
        checkOutput("rst_load", 32'(pc_load), 0);
        checkOutput("rst_pc_next", 32'(pc_next), 0);
        checkOutput("rst_done", 32'(br_done), 0);
        checkOutput("rst_flags", 32'(flags_q), 0);
        checkOutput("rst_ovf", 32'(stk_ovf), 0);
        checkOutput("rst_unf", 32'(stk_unf), 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] taken / not-taken on Co");
        flag_write(7'b0010000);
        applyStimulus(4'd9, 0, 0, 10'h055, 10'h010, 0, 7'h0, 0, 7'h0, 0);
        applyStimulus(4'd10, 0, 0, 10'h066, 10'h011, 0, 7'h0, 0, 7'h0, 0);

        $display("[TB] flag write visibility");
        applyStimulus(4'd3, 0, 0, 10'h123, 10'h020, 1, 7'b0000010, 1, 7'b0000000, 0);
        applyStimulus(4'd3, 0, 0, 10'h124, 10'h021, 0, 7'h0, 1, 7'b0000010, 0);

        $display("[TB] call wrap and return");
        applyStimulus(4'd0, 1, 0, 10'h100, 10'h3FF, 0, 7'h0, 0, 7'h0, 0);
        applyStimulus(4'd0, 0, 1, 10'h2AA, 10'h100, 0, 7'h0, 0, 7'h0, 0);

        $display("[TB] stack fill, overflow, drain, underflow");
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(4'd0, 1, 0, PC_W'(10'h200 + i), PC_W'(10'h030 + 5 * i),
                          0, 7'h0, 0, 7'h0, 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(4'd0, 0, 1, 10'h000, 10'h300, 0, 7'h0, 0, 7'h0, 0);
        end
        clear_errors();

        $display("[TB] never / always, call+ret as ret");
        applyStimulus(4'd15, 1, 0, 10'h0AB, 10'h040, 0, 7'h0, 0, 7'h0, 0);
        applyStimulus(4'd0, 0, 0, 10'h0CD, 10'h041, 0, 7'h0, 0, 7'h0, 0);
        applyStimulus(4'd0, 1, 0, 10'h150, 10'h042, 0, 7'h0, 0, 7'h0, 0);
        applyStimulus(4'd0, 1, 1, 10'h151, 10'h043, 0, 7'h0, 0, 7'h0, 0);

        $display("[TB] reset during EVAL");
        flag_write(7'h7F);
        applyStimulus(4'd0, 1, 0, 10'h160, 10'h050, 0, 7'h0, 0, 7'h0, 0);
        br_valid   = 1'b1;
        br_cond    = 4'd0;
        br_is_call = 1'b0;
        br_is_ret  = 1'b0;
        br_target  = 10'h1EE;
        tick();
        br_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("abort_ready", 32'(br_ready), 1);
        checkOutput("abort_flags", 32'(flags_q), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("abort_no_done", 32'(br_done), 0);
            checkOutput("abort_no_load", 32'(pc_load), 0);
            tick();
        end
        applyStimulus(4'd0, 0, 1, 10'h000, 10'h060, 0, 7'h0, 0, 7'h0, 0);
        clear_errors();

        $display("[TB] random requests");
        for (int n = 0; n < 120; n++) begin
            logic [1:0]      kind;
            logic [PC_W-1:0] pc_r;
            kind = 2'($urandom_range(0, 3));
            pc_r = ($urandom_range(0, 7) == 0) ? 10'h3FF : PC_W'($urandom);
            applyStimulus(4'($urandom_range(0, 15)), kind[0], kind[1],
                          PC_W'($urandom), pc_r,
                          1'($urandom), 7'($urandom),
                          1'($urandom), 7'($urandom),
                          ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
